turn_controller: RTL and testbench
==================================

TURN_CONTROLLER -- requirements
Module: turn_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096, SHALL set the maximum WAIT_AI cycles per search (16-bit range, 1..65535).
REQ-002 Parameter MAX_MOVES, default 200, SHALL set the ply count after which the game halts (1..255).
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port RST_N, input, 1: reset, asynchronous, active-low.
REQ-005 Port start, input, 1: one-cycle pulse that begins a game from IDLE or HALT.
REQ-006 Port stop, input, 1: abort request, honoured in any state.
REQ-007 Ports ai_en (output, 1) and ai_pl (output, 1): launch pulse and side-to-move (1=WHITE, 0=BLACK) to the search engine.
REQ-008 Ports ai_done (input, 1), ai_piece (input, 4) and ai_move (input, 6): engine completion flag, piece code and destination square.
REQ-009 Ports mv_valid (output, 1), mv_ready (input, 1), mv_piece (output, 4), mv_dest (output, 6) and mv_player (output, 1): move handshake to the board-update logic.
REQ-010 Ports busy (output, 1), game_over (output, 1), timeout_err (output, 1) and move_count (output, 8): status.

Function
REQ-011 States SHALL be IDLE, LAUNCH, WAIT_AI, ISSUE, NEXT and HALT.
REQ-012 IDLE: busy=0; start -> LAUNCH, with turn=WHITE, move_count=0, and game_over/timeout_err cleared.
REQ-013 LAUNCH: ai_en=1 for exactly one cycle and ai_pl=turn; next state WAIT_AI; ai_pl SHALL hold turn in every state.
REQ-014 WAIT_AI: stale-done guard. ai_done SHALL be accepted only after it has been sampled low at least once since LAUNCH.
REQ-015 On accepted ai_done: latch ai_piece and ai_move into mv_piece and mv_dest, set mv_player=turn, and go to ISSUE next cycle.
REQ-016 ISSUE: mv_valid=1 with mv_piece, mv_dest and mv_player stable until a cycle where mv_valid&&mv_ready; that cycle -> NEXT.
REQ-017 Handshake latency: mv_ready may already be high on ISSUE entry, giving a one-cycle transfer; mv_valid SHALL never depend combinationally on mv_ready.
REQ-018 NEXT: move_count increments by 1 and turn toggles.
REQ-019 NEXT exit: if the new move_count equals MAX_MOVES -> HALT with game_over=1; otherwise -> LAUNCH.
REQ-020 HALT: busy=0; outputs frozen; start restarts as in REQ-012.
REQ-021 busy=1 in LAUNCH, WAIT_AI, ISSUE and NEXT.
REQ-022 stop SHALL force IDLE on the next edge from any state, dropping mv_valid even mid-handshake; stop SHALL win over a simultaneous start, ai_done or mv_ready.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 move_count SHALL be 8-bit and SHALL never wrap; it SHALL stop at MAX_MOVES.

Reset
REQ-025 RST_N low SHALL immediately put state=IDLE, turn=WHITE and move_count=0.
REQ-026 RST_N low SHALL immediately drive ai_en, mv_valid, busy, game_over and timeout_err to 0.
REQ-027 RST_N low SHALL immediately clear mv_piece, mv_dest and mv_player to 0.
REQ-028 Reset release SHALL take effect on the first clk edge with RST_N high; reset mid-search SHALL discard the search with no mv_valid pulse.

Configuration
REQ-029 With TURN_TIMEOUT_EN defined: a cycle counter runs in WAIT_AI and is cleared in LAUNCH.
REQ-030 With TURN_TIMEOUT_EN, reaching TIMEOUT_CYCLES without an accepted ai_done -> HALT with timeout_err=1.
REQ-031 With TURN_TIMEOUT_EN, ai_done accepted in the same cycle the count reaches TIMEOUT_CYCLES SHALL win: no error is raised.
REQ-032 Without TURN_TIMEOUT_EN: no counter is built, timeout_err is tied 0, and WAIT_AI waits indefinitely.

Structure
REQ-033 Shared package chess_pkg SHALL hold WHITE/BLACK, the 4-bit piece codes (P1..P8, R1, R2, N1, N2, B1, B2, Q1, K1) and the turn_controller state encoding.
REQ-034 The watchdog SHALL be a sub-module turn_watchdog (clear, enable, expired), instantiated only under TURN_TIMEOUT_EN.

Verification
REQ-035 Normal ply: start; ai_done rises 10 cycles after ai_en with piece=4'b0101, move=6'd18; mv_ready=1 -> mv_valid one cycle, mv_piece=5, mv_dest=18, mv_player=1, move_count=1, ai_pl=0.
REQ-036 Stale done: ai_done held high through LAUNCH, low 1 cycle, high again -> only the second rise is accepted, exactly one move issued.
REQ-037 Backpressure: mv_ready low for 7 cycles -> mv_valid and data stable 8 cycles, one transfer, then LAUNCH.
REQ-038 MAX_MOVES=3, engine always answers -> three transfers, players 1,0,1, then HALT with game_over=1, busy=0, move_count=3.
REQ-039 TURN_TIMEOUT_EN, TIMEOUT_CYCLES=16, ai_done never rises -> HALT with timeout_err=1 after 16 WAIT_AI cycles; a repeat with ai_done on cycle 16 -> no error.
REQ-040 stop during ISSUE with mv_ready=0, and RST_N low during WAIT_AI -> IDLE, mv_valid=0, no transfer counted.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared chess definitions: sides, piece codes, move payload and turn_controller state encoding.
package chess_pkg;

  localparam int unsigned PIECE_W = 4;
  localparam int unsigned SQ_W    = 6;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned STATE_W = 3;

  localparam logic WHITE = 1'b1;
  localparam logic BLACK = 1'b0;

  typedef enum logic [PIECE_W-1:0] {
    P1 = 4'd0,  P2 = 4'd1,  P3 = 4'd2,  P4 = 4'd3,
    P5 = 4'd4,  P6 = 4'd5,  P7 = 4'd6,  P8 = 4'd7,
    R1 = 4'd8,  R2 = 4'd9,  N1 = 4'd10, N2 = 4'd11,
    B1 = 4'd12, B2 = 4'd13, Q1 = 4'd14, K1 = 4'd15
  } piece_e;

  typedef struct packed {
    logic [PIECE_W-1:0] piece;
    logic [SQ_W-1:0]    dest;
    logic               player;
  } move_t;

  localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] S_LAUNCH  = 3'd1;
  localparam logic [STATE_W-1:0] S_WAIT_AI = 3'd2;
  localparam logic [STATE_W-1:0] S_ISSUE   = 3'd3;
  localparam logic [STATE_W-1:0] S_NEXT    = 3'd4;
  localparam logic [STATE_W-1:0] S_HALT    = 3'd5;

endpackage

// File: rtl/turn_controller_if.sv
// Engine launch/completion and board-update move handshake between turn_controller and its peers.
interface turn_controller_if;
  import chess_pkg::*;

  logic               ai_en;
  logic               ai_pl;
  logic               ai_done;
  logic [PIECE_W-1:0] ai_piece;
  logic [SQ_W-1:0]    ai_move;
  logic               mv_valid;
  logic               mv_ready;
  logic [PIECE_W-1:0] mv_piece;
  logic [SQ_W-1:0]    mv_dest;
  logic               mv_player;

  modport master (
    output ai_en, ai_pl, mv_valid, mv_piece, mv_dest, mv_player,
    input  ai_done, ai_piece, ai_move, mv_ready
  );

  modport slave (
    input  ai_en, ai_pl, mv_valid, mv_piece, mv_dest, mv_player,
    output ai_done, ai_piece, ai_move, mv_ready
  );

endinterface

// File: rtl/turn_watchdog.sv
// Search watchdog: counts WAIT_AI cycles, flags the last allowed cycle.
// Only compiled with TURN_TIMEOUT_EN defined.
`ifdef TURN_TIMEOUT_EN
module turn_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = 16;

  logic [CW-1:0] cnt;

  // cnt = search cycles already spent; expired is registered one cycle early so it is high during cycle TIMEOUT_CYCLES
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      expired <= (TIMEOUT_CYCLES == 1);
    end else if (enable) begin
      if (cnt != '1) cnt <= cnt + CW'(1);
      expired <= ((17'(cnt) + 17'd2) == 17'(TIMEOUT_CYCLES));
    end
  end

endmodule
`endif

// File: rtl/turn_controller.sv
// Chess turn sequencer: launches the engine per ply, forwards its move over a valid/ready handshake.
// Optional search timeout enabled by defining TURN_TIMEOUT_EN.
module turn_controller
  import chess_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned MAX_MOVES      = 200
) (
  input  logic              clk,
  input  logic              RST_N,
  input  logic              start,
  input  logic              stop,
  turn_controller_if.master io,
  output logic              busy,
  output logic              game_over,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  move_count
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_MOVES);

  if (MAX_MOVES < 1 || MAX_MOVES > 255 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("turn_controller: MAX_MOVES or TIMEOUT_CYCLES out of range");
  end

  logic [STATE_W-1:0] state, next;
  logic               turn, turn_d;
  logic [CNT_W-1:0]   count_d;
  move_t              mv, mv_d;
  logic               seen_low, seen_low_d;
  logic               game_over_d, timeout_err_d;
  logic               busy_d, ai_en_d, mv_valid_d;
  logic               wdg_expired;

`ifdef TURN_TIMEOUT_EN
  turn_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdg (
    .clk     (clk),
    .rst_n   (RST_N),
    .clear   (state == S_LAUNCH),
    .enable  (state == S_WAIT_AI),
    .expired (wdg_expired)
  );
`else
  assign wdg_expired = 1'b0;
`endif

  // Next-state and next-output logic; stop freezes the datapath and forces IDLE
  always_comb begin
    next          = state;
    turn_d        = turn;
    count_d       = move_count;
    mv_d          = mv;
    seen_low_d    = seen_low;
    game_over_d   = game_over;
    timeout_err_d = timeout_err;
    busy_d        = 1'b0;
    ai_en_d       = 1'b0;
    mv_valid_d    = 1'b0;

    if (stop) begin
      next = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            next          = S_LAUNCH;
            turn_d        = WHITE;
            count_d       = '0;
            game_over_d   = 1'b0;
            timeout_err_d = 1'b0;
          end
        end
        S_LAUNCH: begin
          // a done still high from the previous search must be seen low before it counts
          seen_low_d = ~io.ai_done;
          next       = S_WAIT_AI;
        end
        S_WAIT_AI: begin
          if (io.ai_done && seen_low) begin
            mv_d.piece  = io.ai_piece;
            mv_d.dest   = io.ai_move;
            mv_d.player = turn;
            next        = S_ISSUE;
          end else begin
            if (!io.ai_done) seen_low_d = 1'b1;
            if (wdg_expired) begin
              next          = S_HALT;
              timeout_err_d = 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (io.mv_ready) next = S_NEXT;
        end
        S_NEXT: begin
          count_d = move_count + CNT_W'(1);
          turn_d  = (turn == WHITE) ? BLACK : WHITE;
          if (count_d == MAX_CNT) begin
            next        = S_HALT;
            game_over_d = 1'b1;
          end else begin
            next = S_LAUNCH;
          end
        end
        default: next = S_IDLE;
      endcase
    end

    busy_d     = (next == S_LAUNCH) || (next == S_WAIT_AI) || (next == S_ISSUE) || (next == S_NEXT);
    ai_en_d    = (next == S_LAUNCH);
    mv_valid_d = (next == S_ISSUE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      turn        <= WHITE;
      move_count  <= '0;
      mv          <= '0;
      seen_low    <= 1'b0;
      game_over   <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      io.ai_en    <= 1'b0;
      io.mv_valid <= 1'b0;
    end else begin
      state       <= next;
      turn        <= turn_d;
      move_count  <= count_d;
      mv          <= mv_d;
      seen_low    <= seen_low_d;
      game_over   <= game_over_d;
      timeout_err <= timeout_err_d;
      busy        <= busy_d;
      io.ai_en    <= ai_en_d;
      io.mv_valid <= mv_valid_d;
    end
  end

  assign io.ai_pl     = turn;
  assign io.mv_piece  = mv.piece;
  assign io.mv_dest   = mv.dest;
  assign io.mv_player = mv.player;

endmodule

// File: tb/tb_turn_controller.sv
// Scoreboard bench for turn_controller: stimulus pushes expected moves, a monitor checks each presented move.
module tb_turn_controller;
  import chess_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       busy, game_over, timeout_err;
  logic [7:0] move_count;

  turn_controller_if bus();

  turn_controller #(.TIMEOUT_CYCLES(16), .MAX_MOVES(3)) dut (
    .clk         (clk),
    .RST_N       (rst_n),
    .start       (start),
    .stop        (stop),
    .io          (bus),
    .busy        (busy),
    .game_over   (game_over),
    .timeout_err (timeout_err),
    .move_count  (move_count)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  move_t exp_q[$];
  int    transfers = 0;
  int    valid_run = 0;
  int    last_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented move must match the head of the scoreboard; pop on transfer
  always @(negedge clk) begin
    if (bus.mv_valid === 1'b1) begin
      valid_run++;
      check("sb_has_expectation", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("mv_payload", 32'({bus.mv_piece, bus.mv_dest, bus.mv_player}), 32'(exp_q[0]));
        if (bus.mv_ready === 1'b1) begin
          void'(exp_q.pop_front());
          transfers++;
          last_run = valid_run;
        end
      end
    end else begin
      valid_run = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  task automatic wait_ai_en(input int budget);
    int n = 0;
    while (bus.ai_en !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    check("ai_en_seen", 32'(bus.ai_en), 32'd1);
  endtask

  task automatic engine_answer(input int delay, input logic [3:0] pc, input logic [5:0] dst,
                               input logic pl, input bit push);
    move_t m;
    step(delay);
    bus.ai_done  = 1'b1;
    bus.ai_piece = pc;
    bus.ai_move  = dst;
    m = '{piece: pc, dest: dst, player: pl};
    if (push) exp_q.push_back(m);
    step(1);
    bus.ai_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int t0;
    int n;
    bus.ai_done  = 1'b0;
    bus.ai_piece = '0;
    bus.ai_move  = '0;
    bus.mv_ready = 1'b0;

    // Reset values, checked while reset is asserted and before any clock edge
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy",        32'(busy), 32'd0);
    check("rst_game_over",   32'(game_over), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_move_count",  32'(move_count), 32'd0);
    check("rst_ai_en",       32'(bus.ai_en), 32'd0);
    check("rst_mv_valid",    32'(bus.mv_valid), 32'd0);
    check("rst_mv_payload",  32'({bus.mv_piece, bus.mv_dest, bus.mv_player}), 32'd0);
    check("rst_ai_pl",       32'(bus.ai_pl), 32'd1);
    #9 rst_n = 1'b1;
    step(1);
    check("idle_busy", 32'(busy), 32'd0);

    // stop wins over a simultaneous start
    start = 1'b1;
    stop  = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    check("stop_beats_start_busy", 32'(busy), 32'd0);

    // Normal ply: done 10 cycles after ai_en, ready already high
    bus.mv_ready = 1'b1;
    pulse_start();
    wait_ai_en(4);
    check("ply1_busy", 32'(busy), 32'd1);
    check("ply1_ai_pl", 32'(bus.ai_pl), 32'd1);
    engine_answer(10, 4'd5, 6'd18, 1'b1, 1'b1);
    wait_ai_en(6);
    check("ply1_transfers", 32'(transfers), 32'd1);
    check("ply1_valid_cycles", 32'(last_run), 32'd1);
    check("ply1_move_count", 32'(move_count), 32'd1);
    check("ply1_ai_pl_after", 32'(bus.ai_pl), 32'd0);
    do_stop();
    check("stop_idle_busy", 32'(busy), 32'd0);

    // Stale done: high through LAUNCH, low one cycle, high again
    t0 = transfers;
    bus.ai_done  = 1'b1;
    bus.ai_piece = 4'd1;
    bus.ai_move  = 6'd1;
    pulse_start();
    step(2);
    bus.ai_done = 1'b0;
    engine_answer(1, 4'd9, 6'd33, 1'b1, 1'b1);
    step(6);
    check("stale_transfers", 32'(transfers - t0), 32'd1);
    check("stale_sb_empty", 32'(exp_q.size()), 32'd0);
    check("stale_move_count", 32'(move_count), 32'd1);
    do_stop();

    // Backpressure: ready low for 7 ISSUE cycles
    t0 = transfers;
    bus.mv_ready = 1'b0;
    pulse_start();
    wait_ai_en(4);
    engine_answer(3, 4'd15, 6'd63, 1'b1, 1'b1);
    step(7);
    bus.mv_ready = 1'b1;
    step(1);
    check("bp_transfers", 32'(transfers - t0), 32'd1);
    check("bp_valid_cycles", 32'(last_run), 32'd8);
    wait_ai_en(3);
    check("bp_move_count", 32'(move_count), 32'd1);
    do_stop();

    // MAX_MOVES=3: three plies, start ignored mid-game, then HALT
    t0 = transfers;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      wait_ai_en(6);
      engine_answer(2, 4'(i + 10), 6'(i * 7 + 5), (i % 2 == 0) ? WHITE : BLACK, 1'b1);
      if (i == 1) begin
        start = 1'b1;
        step(1);
        start = 1'b0;
      end
    end
    step(4);
    check("max_transfers", 32'(transfers - t0), 32'd3);
    check("max_game_over", 32'(game_over), 32'd1);
    check("max_busy", 32'(busy), 32'd0);
    check("max_move_count", 32'(move_count), 32'd3);
    step(3);
    check("halt_frozen_count", 32'(move_count), 32'd3);
    pulse_start();
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_count", 32'(move_count), 32'd0);
    check("restart_game_over", 32'(game_over), 32'd0);
    do_stop();

`ifdef TURN_TIMEOUT_EN
    // Timeout after 16 WAIT_AI cycles, then done on cycle 16 wins
    pulse_start();
    wait_ai_en(4);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    check("to_cycles_to_halt", 32'(n), 32'd17);
    check("to_timeout_err", 32'(timeout_err), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    t0 = transfers;
    bus.mv_ready = 1'b1;
    pulse_start();
    check("to_restart_clears_err", 32'(timeout_err), 32'd0);
    wait_ai_en(4);
    engine_answer(16, 4'd6, 6'd50, 1'b1, 1'b1);
    wait_ai_en(6);
    check("to_edge_no_err", 32'(timeout_err), 32'd0);
    check("to_edge_transfers", 32'(transfers - t0), 32'd1);
    do_stop();
`else
    // No watchdog: the search waits indefinitely without error
    pulse_start();
    wait_ai_en(4);
    step(40);
    n = 0;
    check("nowdg_busy", 32'(busy), 32'd1);
    check("nowdg_timeout_err", 32'(timeout_err), 32'd0);
    do_stop();
`endif

    // stop during ISSUE with ready low drops mv_valid, nothing transferred
    t0 = transfers;
    bus.mv_ready = 1'b0;
    pulse_start();
    wait_ai_en(4);
    engine_answer(2, 4'd3, 6'd7, 1'b1, 1'b1);
    step(1);
    check("abort_valid_before", 32'(bus.mv_valid), 32'd1);
    do_stop();
    check("abort_mv_valid", 32'(bus.mv_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_move_count", 32'(move_count), 32'd0);
    check("abort_pending", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    step(3);
    check("abort_transfers", 32'(transfers - t0), 32'd0);

    // Reset during the second search clears everything and discards the search
    t0 = transfers;
    bus.mv_ready = 1'b1;
    pulse_start();
    wait_ai_en(4);
    engine_answer(3, 4'd2, 6'd40, 1'b1, 1'b1);
    wait_ai_en(6);
    check("rstmid_count_before", 32'(move_count), 32'd1);
    step(2);
    bus.ai_done  = 1'b1;
    bus.ai_piece = 4'd7;
    bus.ai_move  = 6'd9;
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_move_count", 32'(move_count), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_mv_valid", 32'(bus.mv_valid), 32'd0);
    check("rstmid_ai_pl", 32'(bus.ai_pl), 32'd1);
    #3 rst_n = 1'b1;
    step(5);
    bus.ai_done = 1'b0;
    check("rstmid_transfers", 32'(transfers - t0), 32'd1);
    check("rstmid_idle", 32'(busy), 32'd0);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
